instruction_fetch_ctrl: RTL and testbench
=========================================

# instruction_fetch_ctrl

Parametrised successor of the single-port fetch stage: owns the PC, a word-wide instruction memory loaded by the debug unit, and the IF/ID output register. Adds an explicit LOAD/RUN/HALTED mode machine, jump flush (bubble insertion), HALT-opcode detection and out-of-range PC trapping. Sits between the debug unit loader and the decode stage; stall comes from hazard detection, jump from decode.

## Interface
- `ADDR_WIDTH`, 32: PC / byte-address width.
- `MEM_WORDS_LOG2`, 6: log2 of instruction memory depth in 32-bit words (default 64 words).
- `RESET_PC`, 0: PC value after reset and after reload; must be word aligned.
- `HALT_OPCODE`, 6'b111111: value of instr[31:26] that marks HALT.
- `FLUSH_ON_JUMP`, 1: 1 = instruction register loads NOP on jump; 0 = delay-slot instruction passes.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_reset` in 1: reset, asynchronous, active-high.
- `i_load_we` in 1: loader write strobe (one word per cycle).
- `i_load_addr` in MEM_WORDS_LOG2: loader word address.
- `i_load_data` in 32: loader word.
- `i_start` in 1: LOAD→RUN.
- `i_reload` in 1: HALTED→LOAD.
- `i_jump` in 1: redirect PC.
- `i_jump_addr` in ADDR_WIDTH: jump target (byte address).
- `i_stall` in 1: hazard stall, holds PC and output register.
- `i_halt` in 1: debug freeze, holds PC and output register.
- `o_instruction` out 32: IF/ID instruction.
- `o_pc4` out ADDR_WIDTH: PC of `o_instruction` + 4.
- `o_valid` out 1: `o_instruction` is a real fetched instruction.
- `o_state` out 2: 0 LOAD, 1 RUN, 2 HALTED.
- `o_addr_err` out 1: sticky out-of-range PC flag.
- `o_load_err` out 1: one-cycle pulse when a write is attempted outside LOAD.

## Operation
- Reset (async): state LOAD, PC=RESET_PC, `o_instruction`=0, `o_pc4`=RESET_PC+4, `o_valid`=0, `o_addr_err`=0, `o_load_err`=0. Memory contents not cleared.
- LOAD: `i_load_we` writes `i_load_data` at word `i_load_addr`. PC and output register held; `o_valid`=0. `i_start` without `i_load_we` in the same cycle → RUN; with `i_load_we`, the write is performed and `i_start` is ignored.
- RUN, per cycle, in priority order:
  - `i_halt`: everything holds.
  - `i_jump`: PC←`i_jump_addr`. Output register loads NOP with `o_valid`=0 if FLUSH_ON_JUMP, else the current fetch. Jump overrides `i_stall`.
  - `i_stall`: PC and output register hold.
  - Otherwise: output register←mem[PC word index], `o_pc4`←PC+4, `o_valid`=1, PC←PC+4.
- Word index = PC[MEM_WORDS_LOG2+1:2]. A fetch with any of PC[ADDR_WIDTH-1:MEM_WORDS_LOG2+2] nonzero, or PC[1:0]≠0, sets `o_addr_err`, loads NOP with `o_valid`=0 and goes to HALTED.
- HALT: when a fetched word has instr[31:26]=HALT_OPCODE, it is registered with `o_valid`=1, PC stops (not incremented), and state→HALTED in the same edge.
- HALTED: PC and output register hold. `i_reload` → LOAD, PC=RESET_PC, `o_valid`=0, `o_addr_err` cleared.
- `i_load_we` in RUN/HALTED: no write, `o_load_err` pulses for 1 cycle.
- PC arithmetic is modulo 2^ADDR_WIDTH.

## Timing
- Memory read is combinational. Instruction latency is 1 cycle: PC presented in cycle n → `o_instruction` valid after edge n+1.
- A jump in cycle n makes the target fetched at edge n+1 and visible after edge n+2. With flush, one bubble is inserted.
- A loader write at edge n is readable by a fetch in cycle n+1.
- Mode transitions take effect at the edge where the request is sampled.
- Reset asserted mid-RUN forces reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `fetch_pkg`: state encoding constants (`ST_LOAD`, `ST_RUN`, `ST_HALTED`), `NOP_INSTR`=32'h0, and the default HALT opcode.
- One sub-module `imem_word_ram`: a single write port and one asynchronous read port, parametrised by MEM_WORDS_LOG2, 32-bit words. Reads and writes use separate address inputs, so no address mux is needed.
- PC register, mode FSM and the IF/ID register live in the top module.

## Test plan
- Load words 0..3 = 0x20010005, 0x20020007, 0x00221820, 0xFC000000, then `i_start` → `o_instruction` shows these words on consecutive cycles with `o_pc4` = 4, 8, 12, 16. On the 4th word, state becomes HALTED and the PC stays at 12.
- RUN with `i_jump`=1 and `i_jump_addr`=0x20 at cycle n → next `o_instruction`=0 with `o_valid`=0, then mem[8] with `o_pc4`=0x24. With FLUSH_ON_JUMP=0, the word at the old PC appears instead of the bubble.
- `i_stall` high for 3 cycles → `o_instruction` and `o_pc4` unchanged for those 3 cycles. Asserting `i_jump` during the stall still redirects the PC.
- `i_jump_addr`=0x100 (MEM_WORDS_LOG2=6) → `o_addr_err`=1, state HALTED. Then `i_reload` → LOAD, PC=0, flag cleared.
- `i_load_we` in RUN → no change to memory contents and a 1-cycle `o_load_err` pulse. `i_start` together with `i_load_we` in LOAD → write done and state stays LOAD.
- Assert `i_reset` asynchronously between clock edges while in RUN → outputs return to reset values before the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: mode encoding,
// the NOP word used for bubbles and the default HALT opcode.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR           = 32'h0000_0000;
    localparam logic [5:0]  DEFAULT_HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/imem_word_ram.sv
// Word-wide instruction memory: one synchronous write port for the loader
// and one combinational read port for the fetch path.
module imem_word_ram #(
    parameter int MEM_WORDS_LOG2 = 6
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [MEM_WORDS_LOG2-1:0] i_waddr,
    input  logic [31:0]               i_wdata,
    input  logic [MEM_WORDS_LOG2-1:0] i_raddr,
    output logic [31:0]               o_rdata
);

    localparam int DEPTH = 2 ** MEM_WORDS_LOG2;

    // Contents are deliberately not reset so a program survives a core reset.
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Fetch stage: PC register, LOAD/RUN/HALTED mode machine and the IF/ID
// output register, in front of a loader-filled instruction memory.
module instruction_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    MEM_WORDS_LOG2 = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter logic [5:0]            HALT_OPCODE    = DEFAULT_HALT_OPCODE,
    parameter bit                    FLUSH_ON_JUMP  = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_load_we,
    input  logic [MEM_WORDS_LOG2-1:0] i_load_addr,
    input  logic [31:0]               i_load_data,
    input  logic                      i_start,
    input  logic                      i_reload,
    input  logic                      i_jump,
    input  logic [ADDR_WIDTH-1:0]     i_jump_addr,
    input  logic                      i_stall,
    input  logic                      i_halt,
    output logic [31:0]               o_instruction,
    output logic [ADDR_WIDTH-1:0]     o_pc4,
    output logic                      o_valid,
    output logic [1:0]                o_state,
    output logic                      o_addr_err,
    output logic                      o_load_err
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pc4;
    logic [31:0]           r_instr;
    logic                  r_valid;
    logic                  r_addr_err;
    logic                  r_load_err;

    logic                      w_ram_we;
    logic [MEM_WORDS_LOG2-1:0] w_word_idx;
    logic [31:0]               w_fetch_word;
    logic                      w_pc_bad;
    logic                      w_is_halt;
    logic [ADDR_WIDTH-1:0]     w_pc_seq;

    assign w_ram_we   = i_load_we && (r_state == ST_LOAD);
    assign w_word_idx = r_pc[MEM_WORDS_LOG2+1:2];
    // Any address bit above the memory span, or a misaligned PC, is a trap.
    assign w_pc_bad   = ((r_pc >> (MEM_WORDS_LOG2 + 2)) != '0) || (r_pc[1:0] != 2'b00);
    assign w_is_halt  = (w_fetch_word[31:26] == HALT_OPCODE);
    assign w_pc_seq   = r_pc + PC_STEP;

    imem_word_ram #(
        .MEM_WORDS_LOG2(MEM_WORDS_LOG2)
    ) u_imem (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_raddr (w_word_idx),
        .o_rdata (w_fetch_word)
    );

    // o_valid qualifies o_instruction for decode; while stalled or halted the
    // register holds, so a valid word stays presented until a fetch replaces it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_LOAD;
            r_pc       <= RESET_PC;
            r_pc4      <= RESET_PC + PC_STEP;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
            r_addr_err <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= i_load_we && (r_state != ST_LOAD);
            case (r_state)
                ST_LOAD: begin
                    if (!i_load_we && i_start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!i_halt) begin
                        if (i_jump) begin
                            r_pc  <= i_jump_addr;
                            r_pc4 <= w_pc_seq;
                            if (FLUSH_ON_JUMP || w_pc_bad) begin
                                r_instr <= NOP_INSTR;
                                r_valid <= 1'b0;
                            end else begin
                                r_instr <= w_fetch_word;
                                r_valid <= 1'b1;
                            end
                        end else if (!i_stall) begin
                            if (w_pc_bad) begin
                                r_addr_err <= 1'b1;
                                r_instr    <= NOP_INSTR;
                                r_valid    <= 1'b0;
                                r_state    <= ST_HALTED;
                            end else begin
                                r_instr <= w_fetch_word;
                                r_valid <= 1'b1;
                                r_pc4   <= w_pc_seq;
                                // A HALT word is delivered but the PC parks on it.
                                if (w_is_halt) begin
                                    r_state <= ST_HALTED;
                                end else begin
                                    r_pc <= w_pc_seq;
                                end
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    if (i_reload) begin
                        r_state    <= ST_LOAD;
                        r_pc       <= RESET_PC;
                        r_valid    <= 1'b0;
                        r_addr_err <= 1'b0;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign o_instruction = r_instr;
    assign o_pc4         = r_pc4;
    assign o_valid       = r_valid;
    assign o_state       = r_state;
    assign o_addr_err    = r_addr_err;
    assign o_load_err    = r_load_err;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Bench for instruction_fetch_ctrl: two instances (flush / delay-slot) driven
// identically and compared each cycle against a behavioural fetch model.
module tb_instruction_fetch_ctrl;

    localparam int AW    = 32;
    localparam int ML    = 6;
    localparam int DEPTH = 64;

    logic          clk;
    logic          rst;
    logic          load_we;
    logic [ML-1:0] load_addr;
    logic [31:0]   load_data;
    logic          start;
    logic          reload;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic          stall;
    logic          halt;

    logic [31:0]   o_instr  [2];
    logic [AW-1:0] o_pc4    [2];
    logic          o_valid  [2];
    logic [1:0]    o_state  [2];
    logic          o_aerr   [2];
    logic          o_lerr   [2];

    instruction_fetch_ctrl #(.FLUSH_ON_JUMP(1'b1)) u_dut_flush (
        .i_clk(clk), .i_reset(rst), .i_load_we(load_we), .i_load_addr(load_addr),
        .i_load_data(load_data), .i_start(start), .i_reload(reload), .i_jump(jump),
        .i_jump_addr(jump_addr), .i_stall(stall), .i_halt(halt),
        .o_instruction(o_instr[0]), .o_pc4(o_pc4[0]), .o_valid(o_valid[0]),
        .o_state(o_state[0]), .o_addr_err(o_aerr[0]), .o_load_err(o_lerr[0])
    );

    instruction_fetch_ctrl #(.FLUSH_ON_JUMP(1'b0)) u_dut_delay (
        .i_clk(clk), .i_reset(rst), .i_load_we(load_we), .i_load_addr(load_addr),
        .i_load_data(load_data), .i_start(start), .i_reload(reload), .i_jump(jump),
        .i_jump_addr(jump_addr), .i_stall(stall), .i_halt(halt),
        .o_instruction(o_instr[1]), .o_pc4(o_pc4[1]), .o_valid(o_valid[1]),
        .o_state(o_state[1]), .o_addr_err(o_aerr[1]), .o_load_err(o_lerr[1])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode: 0 load, 1 run, 2 halted. Index 0 = flushing core, 1 = delay-slot core.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_instr [2];
    logic        m_valid [2];
    logic        m_aerr;
    logic        m_lerr;
    logic [31:0] m_mem   [DEPTH];
    logic [31:0] exp_q[$];

    function automatic bit pc_ok(input logic [31:0] pc);
        return (pc < 32'(DEPTH * 4)) && (pc % 4 == 0);
    endfunction

    task automatic push_expected();
        exp_q.push_back(m_instr[0]);
        exp_q.push_back(m_instr[1]);
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_pc4  = 4;
        m_aerr = 0;
        m_lerr = 0;
        for (int k = 0; k < 2; k++) begin
            m_instr[k] = 0;
            m_valid[k] = 0;
        end
        push_expected();
    endtask

    task automatic model_step();
        logic [31:0] word;
        bit          ok;
        ok     = pc_ok(m_pc);
        word   = m_mem[(m_pc / 4) % DEPTH];
        m_lerr = load_we && (m_mode != 0);
        if (m_mode == 0) begin
            if (load_we) m_mem[load_addr] = load_data;
            else if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!halt && jump) begin
                m_instr[0] = 0;
                m_valid[0] = 0;
                m_instr[1] = ok ? word : 32'h0;
                m_valid[1] = ok;
                m_pc4      = m_pc + 4;
                m_pc       = jump_addr;
            end else if (!halt && !stall) begin
                if (!ok) begin
                    m_aerr = 1;
                    m_mode = 2;
                    for (int k = 0; k < 2; k++) begin
                        m_instr[k] = 0;
                        m_valid[k] = 0;
                    end
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        m_instr[k] = word;
                        m_valid[k] = 1;
                    end
                    m_pc4 = m_pc + 4;
                    if (word[31:26] == 6'h3f) m_mode = 2;
                    else m_pc = m_pc + 4;
                end
            end
        end else if (reload) begin
            m_mode     = 0;
            m_pc       = 0;
            m_aerr     = 0;
            m_valid[0] = 0;
            m_valid[1] = 0;
        end
        push_expected();
    endtask

    task automatic check_outputs();
        logic [31:0] exp_instr;
        for (int k = 0; k < 2; k++) begin
            if (exp_q.size() == 0) begin
                check_eq("exp_q_empty", 32'd1, 32'd0);
                exp_instr = 32'hx;
            end else begin
                exp_instr = exp_q.pop_front();
            end
            check_eq($sformatf("instr%0d", k), o_instr[k], exp_instr);
            check_eq($sformatf("pc4_%0d", k), o_pc4[k], m_pc4);
            check_eq($sformatf("valid%0d", k), 32'(o_valid[k]), 32'(m_valid[k]));
            check_eq($sformatf("state%0d", k), 32'(o_state[k]), 32'(m_mode));
            check_eq($sformatf("addr_err%0d", k), 32'(o_aerr[k]), 32'(m_aerr));
            check_eq($sformatf("load_err%0d", k), 32'(o_lerr[k]), 32'(m_lerr));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        load_we   = 0;
        load_addr = '0;
        load_data = '0;
        start     = 0;
        reload    = 0;
        jump      = 0;
        jump_addr = '0;
        stall     = 0;
        halt      = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic load_word(input logic [ML-1:0] addr, input logic [31:0] data);
        load_we   = 1;
        load_addr = addr;
        load_data = data;
        step();
        load_we   = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic pulse_reload();
        reload = 1;
        step();
        reload = 0;
    endtask

    task automatic do_jump(input logic [AW-1:0] target);
        jump      = 1;
        jump_addr = target;
        step();
        jump      = 0;
    endtask

    // Reset lands mid-cycle; outputs must already be at reset values before the next edge.
    task automatic async_reset();
        #2;
        rst = 1;
        #1;
        model_reset();
        check_outputs();
        #1;
        rst = 0;
    endtask

    function automatic logic [31:0] rnd_word(input int halt_pct);
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(99) < halt_pct) w[31:26] = 6'h3f;
        else if (w[31:26] == 6'h3f) w[31:26] = 6'h3e;
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] data;
        idle();
        rst = 1;
        #3;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 0;

        // Program: the four-word sequence ending in HALT, rest non-HALT filler.
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0: data = 32'h2001_0005;
                1: data = 32'h2002_0007;
                2: data = 32'h0022_1820;
                3: data = 32'hFC00_0000;
                default: data = rnd_word(0);
            endcase
            load_word(ML'(i), data);
        end
        pulse_start();
        repeat (4) step();
        check_eq("halt_state", 32'(o_state[0]), 32'd2);
        check_eq("halt_pc4", o_pc4[0], 32'd16);
        repeat (2) step();

        // Jump with bubble vs. delay slot.
        pulse_reload();
        pulse_start();
        step();
        do_jump(32'h20);
        check_eq("bubble_valid", 32'(o_valid[0]), 32'd0);
        step();
        check_eq("target_pc4", o_pc4[0], 32'h24);
        step();

        // Stall for three cycles, then a jump during the stall.
        stall = 1;
        repeat (3) step();
        do_jump(32'h10);
        stall = 0;
        repeat (2) step();

        // Out-of-range trap, write attempt while halted, reload.
        do_jump(32'h100);
        step();
        check_eq("trap_err", 32'(o_aerr[0]), 32'd1);
        load_word(ML'(2), 32'hDEAD_BEEF);
        step();
        pulse_reload();

        // Start together with a write stays in LOAD; a write in RUN is refused.
        start = 1;
        load_word(ML'(5), 32'h1234_5678);
        start = 0;
        pulse_start();
        load_word(ML'(1), 32'hCAFE_F00D);
        step();
        step();
        async_reset();

        // Randomized episodes.
        for (int ep = 0; ep < 30; ep++) begin
            repeat ($urandom_range(1, 6)) begin
                start = ($urandom_range(3) == 0);
                load_word(ML'($urandom_range(DEPTH - 1)), rnd_word(15));
                start = 0;
            end
            pulse_start();
            for (int c = 0; c < 40 && m_mode == 1; c++) begin
                halt      = ($urandom_range(7) == 0);
                jump      = ($urandom_range(7) == 0);
                jump_addr = ($urandom_range(9) == 0) ? 32'($urandom)
                                                     : 32'($urandom_range(DEPTH - 1) * 4);
                stall     = ($urandom_range(4) == 0);
                load_we   = ($urandom_range(9) == 0);
                load_addr = ML'($urandom_range(DEPTH - 1));
                load_data = $urandom;
                reload    = ($urandom_range(9) == 0);
                start     = ($urandom_range(9) == 0);
                step();
            end
            idle();
            if (m_mode == 1 && (ep % 7) == 3) begin
                async_reset();
            end else if (m_mode == 1) begin
                do_jump(32'h100);
                for (int c = 0; c < 3 && m_mode == 1; c++) step();
            end
            if (m_mode == 2) begin
                step();
                pulse_reload();
            end
            if (m_mode != 0) check_eq("episode_end_mode", 32'(m_mode), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
